// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ram_port_arbiter                                           |
// | Description : Two-port arbiter for a single-port synchronous RAM.        |
// |               Port A (CPU) and port B (loader/DMA) are serviced through  |
// |               a fixed-latency IDLE/ACCESS/CAPTURE/DONE sequence. Ties    |
// |               are resolved round-robin, and port-A writes into the       |
// |               [PROT_LO, PROT_HI] window are suppressed and flagged.      |
// | Ports       : ARB_clk/ARB_rst_n  clock, async active-low reset           |
// |               A_*/B_*            requester handshakes (req/we/addr/wdata |
// |                                  in; gnt/done/rdata out; A_err on A)    |
// |               RAM_*              RAM strobes, address, data             |
// |               Busy/Owner         not-idle flag, last granted port (1=B) |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ram_port_arbiter #(
    parameter logic       PROT_EN = 1'b1,
    parameter logic [7:0] PROT_LO = 8'hF0,
    parameter logic [7:0] PROT_HI = 8'hFF
) (
    input  logic       ARB_clk,
    input  logic       ARB_rst_n,
    input  logic       A_req,
    input  logic       A_we,
    input  logic [7:0] A_addr,
    input  logic [7:0] A_wdata,
    output logic       A_gnt,
    output logic       A_done,
    output logic       A_err,
    output logic [7:0] A_rdata,
    input  logic       B_req,
    input  logic       B_we,
    input  logic [7:0] B_addr,
    input  logic [7:0] B_wdata,
    output logic       B_gnt,
    output logic       B_done,
    output logic [7:0] B_rdata,
    output logic       RAM_en,
    output logic       RAM_we,
    output logic [7:0] RAM_addr,
    output logic [7:0] RAM_wdata,
    input  logic [7:0] RAM_rdata,
    output logic       Busy,
    output logic       Owner
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       prot_q, prot_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;
    logic       a_gnt_q, a_gnt_d;
    logic       b_gnt_q, b_gnt_d;
    logic       a_done_q, a_done_d;
    logic       b_done_q, b_done_d;
    logic       a_err_q, a_err_d;
    logic       ram_en_q, ram_en_d;
    logic       ram_we_q, ram_we_d;
    logic       busy_q, busy_d;

    always_ff @(posedge ARB_clk or negedge ARB_rst_n) begin
        if (!ARB_rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b1;      // A wins the first tie
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            prot_q    <= 1'b0;
            a_rdata_q <= 8'h00;
            b_rdata_q <= 8'h00;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            ram_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            prot_q    <= prot_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_gnt_q   <= a_gnt_d;
            b_gnt_q   <= b_gnt_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_err_q   <= a_err_d;
            ram_en_q  <= ram_en_d;
            ram_we_q  <= ram_we_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        prot_d    = prot_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (A_req || B_req) begin
                    // On a tie the port that did not win last time goes next.
                    owner_d = (A_req && B_req) ? ~owner_q : B_req;
                    we_d    = owner_d ? B_we    : A_we;
                    addr_d  = owner_d ? B_addr  : A_addr;
                    wdata_d = owner_d ? B_wdata : A_wdata;
                    // Zero-extended compare keeps the window test unsigned and
                    // lets an inverted window (LO > HI) match nothing.
                    prot_d  = PROT_EN && !owner_d && we_d &&
                              ({1'b0, addr_d} >= {1'b0, PROT_LO}) &&
                              ({1'b0, addr_d} <= {1'b0, PROT_HI});
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS:  state_d = we_q ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE: begin
                state_d = ST_DONE;
                if (owner_q) b_rdata_d = RAM_rdata;
                else         a_rdata_d = RAM_rdata;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered rather than the current one.
        busy_d   = (state_d != ST_IDLE);
        a_gnt_d  = busy_d && !owner_d;
        b_gnt_d  = busy_d && owner_d;
        ram_en_d = (state_d == ST_ACCESS) && !prot_d;
        ram_we_d = ram_en_d && we_d;
        a_done_d = (state_d == ST_DONE) && !owner_d;
        b_done_d = (state_d == ST_DONE) && owner_d;
        a_err_d  = a_done_d && prot_d;
    end

    assign A_gnt     = a_gnt_q;
    assign A_done    = a_done_q;
    assign A_err     = a_err_q;
    assign A_rdata   = a_rdata_q;
    assign B_gnt     = b_gnt_q;
    assign B_done    = b_done_q;
    assign B_rdata   = b_rdata_q;
    assign RAM_en    = ram_en_q;
    assign RAM_we    = ram_we_q;
    assign RAM_addr  = addr_q;
    assign RAM_wdata = wdata_q;
    assign Busy      = busy_q;
    assign Owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ram_port_arbiter                                        |
// | Description : Self-checking bench for ram_port_arbiter with a behavioural|
// |               RAM and a timeline-based reference model.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;

    localparam logic [7:0] C_PROT_LO = 8'hF0;
    localparam logic [7:0] C_PROT_HI = 8'hFF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
    logic       A_gnt, A_done, A_err, B_gnt, B_done;
    logic [7:0] A_rdata, B_rdata;
    logic       RAM_en, RAM_we, Busy, Owner;
    logic [7:0] RAM_addr, RAM_wdata;
    logic [7:0] ram_rdata;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .PROT_EN (1'b1),
        .PROT_LO (C_PROT_LO),
        .PROT_HI (C_PROT_HI)
    ) dut (
        .ARB_clk   (clk),
        .ARB_rst_n (rst_n),
        .A_req     (a_req),
        .A_we      (a_we),
        .A_addr    (a_addr),
        .A_wdata   (a_wdata),
        .A_gnt     (A_gnt),
        .A_done    (A_done),
        .A_err     (A_err),
        .A_rdata   (A_rdata),
        .B_req     (b_req),
        .B_we      (b_we),
        .B_addr    (b_addr),
        .B_wdata   (b_wdata),
        .B_gnt     (B_gnt),
        .B_done    (B_done),
        .B_rdata   (B_rdata),
        .RAM_en    (RAM_en),
        .RAM_we    (RAM_we),
        .RAM_addr  (RAM_addr),
        .RAM_wdata (RAM_wdata),
        .RAM_rdata (ram_rdata),
        .Busy      (Busy),
        .Owner     (Owner)
    );

    // Behavioural single-port synchronous RAM.
    function automatic logic [7:0] ram_init(input logic [7:0] a);
        return (a == 8'h10) ? 8'h5A : (a ^ 8'hA5);
    endfunction

    logic [7:0] mem [256];
    logic       fill = 1'b0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= ram_init(8'(i));
        end else if (RAM_en) begin
            if (RAM_we) mem[RAM_addr] <= RAM_wdata;
            else        ram_rdata     <= mem[RAM_addr];
        end
    end

    // Reference model: an access is a timeline of phases 1..len after the
    // grant edge (len 3 for a read, 2 for a write); phase 0 means idle.
    int         checks = 0;
    int         errors = 0;
    logic [7:0] shadow [256];
    int         phase = 0;
    int         m_len = 0;
    logic       m_own = 1'b1, m_we = 1'b0, m_prot = 1'b0;
    logic [7:0] m_addr = 8'h00, m_wdata = 8'h00;
    logic [7:0] exp_ard = 8'h00, exp_brd = 8'h00;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase   = 0;
        m_own   = 1'b1;
        exp_ard = 8'h00;
        exp_brd = 8'h00;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        if (phase == 0) begin
            if (a_req || b_req) begin
                m_own   = (a_req && b_req) ? ~m_own : b_req;
                m_we    = m_own ? b_we    : a_we;
                m_addr  = m_own ? b_addr  : a_addr;
                m_wdata = m_own ? b_wdata : a_wdata;
                m_prot  = !m_own && m_we && (m_addr >= C_PROT_LO) && (m_addr <= C_PROT_HI);
                m_len   = m_we ? 2 : 3;
                phase   = 1;
            end
        end else begin
            if (phase == 1 && m_we && !m_prot) shadow[m_addr] = m_wdata;
            if (phase == 2 && !m_we) begin
                if (m_own) exp_brd = shadow[m_addr];
                else       exp_ard = shadow[m_addr];
            end
            phase = (phase == m_len) ? 0 : phase + 1;
        end
    endtask

    task automatic check_outputs();
        logic busy, done;
        busy = (phase != 0);
        done = busy && (phase == m_len);
        check1("A_gnt",  A_gnt,  busy && !m_own);
        check1("B_gnt",  B_gnt,  busy && m_own);
        check1("gnt_overlap", A_gnt && B_gnt, 1'b0);
        check1("A_done", A_done, done && !m_own);
        check1("B_done", B_done, done && m_own);
        check1("A_err",  A_err,  done && !m_own && m_prot);
        check1("RAM_en", RAM_en, (phase == 1) && !m_prot);
        check1("RAM_we", RAM_we, (phase == 1) && !m_prot && m_we);
        check1("Busy",   Busy,   busy);
        check1("Owner",  Owner,  m_own);
        check8("A_rdata", A_rdata, exp_ard);
        check8("B_rdata", B_rdata, exp_brd);
        if (phase == 1) check8("RAM_addr", RAM_addr, m_addr);
        if (phase == 1 && m_we && !m_prot) check8("RAM_wdata", RAM_wdata, m_wdata);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_A_gnt"},  A_gnt,  1'b0);
        check1({tag, "_B_gnt"},  B_gnt,  1'b0);
        check1({tag, "_A_done"}, A_done, 1'b0);
        check1({tag, "_B_done"}, B_done, 1'b0);
        check1({tag, "_A_err"},  A_err,  1'b0);
        check1({tag, "_RAM_en"}, RAM_en, 1'b0);
        check1({tag, "_RAM_we"}, RAM_we, 1'b0);
        check1({tag, "_Busy"},   Busy,   1'b0);
        check1({tag, "_Owner"},  Owner,  1'b1);
        check8({tag, "_RAM_addr"},  RAM_addr,  8'h00);
        check8({tag, "_RAM_wdata"}, RAM_wdata, 8'h00);
        check8({tag, "_A_rdata"},   A_rdata,   8'h00);
        check8({tag, "_B_rdata"},   B_rdata,   8'h00);
    endtask

    task automatic do_reset();
        a_req = 1'b0;
        b_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_reset_values("rst");
        rst_n = 1'b1;
    endtask

    task automatic a_set(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic b_set(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 8'hF0;
            1:       return 8'hEF;
            2:       return 8'hFF;
            3:       return 8'hF4;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grants;
        logic exp_next;

        // Preload RAM and the shadow copy while reset is held.
        fill = 1'b1;
        @(posedge clk);
        #1;
        fill = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = ram_init(8'(i));
        do_reset();

        // A read of 8'h10.
        a_set(1'b1, 1'b0, 8'h10, 8'h00);
        step();
        check1("t1_A_gnt_C1", A_gnt, 1'b1);
        check1("t1_RAM_en_C1", RAM_en, 1'b1);
        check8("t1_RAM_addr_C1", RAM_addr, 8'h10);
        step();
        step();
        check1("t1_A_done_C3", A_done, 1'b1);
        check8("t1_A_rdata", A_rdata, 8'h5A);
        check1("t1_B_gnt", B_gnt, 1'b0);
        a_req = 1'b0;
        step();

        // B write 8'hC3 to 8'h20, then A reads it back.
        b_set(1'b1, 1'b1, 8'h20, 8'hC3);
        step();
        check1("t2_RAM_we_C1", RAM_we, 1'b1);
        step();
        check1("t2_B_done_C2", B_done, 1'b1);
        check1("t2_RAM_we_C2", RAM_we, 1'b0);
        b_req = 1'b0;
        step();
        a_set(1'b1, 1'b0, 8'h20, 8'h00);
        repeat (3) step();
        check8("t2_A_rdata", A_rdata, 8'hC3);
        a_req = 1'b0;
        step();

        // Continuous contention: grants alternate starting with A.
        do_reset();
        a_set(1'b1, 1'b0, 8'h33, 8'h00);
        b_set(1'b1, 1'b1, 8'h33, 8'h9E);
        grants   = 0;
        exp_next = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (phase == 1) begin
                grants++;
                check1("t3_rr_owner", Owner, exp_next);
                check1("t3_rr_gnt", exp_next ? B_gnt : A_gnt, 1'b1);
                exp_next = ~exp_next;
            end
        end
        check8("t3_grant_count", 8'(grants), 8'd6);
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 6 && phase != 0; i++) step();
        step();

        // Protected A write, then B observes the old value and can overwrite it.
        a_set(1'b1, 1'b1, 8'hF4, 8'h77);
        step();
        check1("t4_RAM_en_prot", RAM_en, 1'b0);
        check1("t4_RAM_we_prot", RAM_we, 1'b0);
        step();
        check1("t4_A_done", A_done, 1'b1);
        check1("t4_A_err", A_err, 1'b1);
        a_req = 1'b0;
        step();
        b_set(1'b1, 1'b0, 8'hF4, 8'h00);
        repeat (3) step();
        check8("t4_B_old", B_rdata, 8'h51);
        b_req = 1'b0;
        step();
        b_set(1'b1, 1'b1, 8'hF4, 8'h55);
        repeat (2) step();
        check1("t4_B_err_free", A_err, 1'b0);
        b_req = 1'b0;
        step();
        b_set(1'b1, 1'b0, 8'hF4, 8'h00);
        repeat (3) step();
        check8("t4_B_new", B_rdata, 8'h55);
        b_req = 1'b0;
        step();
        // Window edges: 8'hFF blocked, 8'hEF allowed.
        a_set(1'b1, 1'b1, 8'hFF, 8'h12);
        repeat (2) step();
        check1("t4_err_FF", A_err, 1'b1);
        a_req = 1'b0;
        step();
        a_set(1'b1, 1'b1, 8'hEF, 8'h34);
        step();
        check1("t4_we_EF", RAM_we, 1'b1);
        step();
        check1("t4_err_EF", A_err, 1'b0);
        a_req = 1'b0;
        step();

        // A drops its request in C1; the read still completes.
        a_set(1'b1, 1'b0, 8'h30, 8'h00);
        step();
        a_req = 1'b0;
        step();
        step();
        check1("t5_A_done", A_done, 1'b1);
        step();
        check1("t5_Busy", Busy, 1'b0);

        // Reset during the ACCESS cycle of a B write.
        b_set(1'b1, 1'b1, 8'h40, 8'h99);
        step();
        check1("t6_RAM_we_pre", RAM_we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("t6_RAM_we_async", RAM_we, 1'b0);
        check1("t6_RAM_en_async", RAM_en, 1'b0);
        check1("t6_B_gnt_async", B_gnt, 1'b0);
        b_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check1("t6_no_B_done", B_done, 1'b0);
        rst_n = 1'b1;
        check_reset_values("t6");
        step();
        b_set(1'b1, 1'b0, 8'h40, 8'h00);
        repeat (3) step();
        check8("t6_write_lost", B_rdata, 8'h40 ^ 8'hA5);
        b_req = 1'b0;
        step();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!a_req || (phase != 0 && phase == m_len && !m_own)) begin
                a_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            end
            if (!b_req || (phase != 0 && phase == m_len && m_own)) begin
                b_set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
